// File: rtl/imem_arbiter.sv
// imem_arbiter: single-port instruction memory shared by the fetch stage and
// the program loader. The loader normally has priority, but after MAX_LD_RUN
// consecutive loader grants with a fetch waiting, the fetch gets one slot.
// Optional feature: define IMEM_ARB_ERR_EN to get a sticky ld_err flag for
// dropped out-of-range loader writes; otherwise ld_err is tied low.
module imem_arbiter #(
  parameter int MAX_LD_RUN  = 4,
  parameter int DEPTH_WORDS = 256,
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  // fetch port
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic          stall_fetch,
  output logic          fetch_rvalid,
  output logic [31:0]   fetch_rdata,
  // loader port
  input  logic          ld_valid,
  input  logic [31:0]   ld_addr,
  input  logic [31:0]   ld_wdata,
  output logic          ld_ready,
  output logic          ld_err,
  // memory port
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [3:0]  RUN_MAX   = 4'(MAX_LD_RUN);
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

  logic [3:0] run_cnt;
  logic       fetch_oor;
  logic       ld_oor;
  logic       grant_ld;
  logic       grant_fetch;
  logic       fetch_oor_q;
  logic [3:0] unused_byte_bits;

  // Byte-offset bits of both addresses are ignored.
  assign unused_byte_bits = {fetch_addr[1:0], ld_addr[1:0]};

  // Arbitration and memory port steering.
  always_comb begin
    fetch_oor   = (fetch_addr[31:2] >= DEPTH_LIM);
    ld_oor      = (ld_addr[31:2] >= DEPTH_LIM);
    // Loader wins while under its run budget, or whenever fetch is idle.
    grant_ld    = ld_valid && ((run_cnt < RUN_MAX) || !fetch_req);
    grant_fetch = fetch_req && !grant_ld;

    stall_fetch = fetch_req && !grant_fetch;
    ld_ready    = grant_ld;
    mem_en      = (grant_ld && !ld_oor) || (grant_fetch && !fetch_oor);
    mem_we      = grant_ld && !ld_oor;
    mem_addr    = grant_ld ? ld_addr[2 +: AW] : fetch_addr[2 +: AW];
    mem_wdata   = ld_wdata;
  end

  // Consecutive loader grants while a fetch is waiting; saturates at the budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
    end else if (!fetch_req || grant_fetch) begin
      run_cnt <= '0;
    end else if (grant_ld && (run_cnt < RUN_MAX)) begin
      run_cnt <= run_cnt + 4'd1;
    end
  end

  // Read response tracking: valid one cycle after a fetch grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_rvalid <= 1'b0;
      fetch_oor_q  <= 1'b0;
    end else begin
      fetch_rvalid <= grant_fetch;
      fetch_oor_q  <= grant_fetch && fetch_oor;
    end
  end

  // Memory already has one cycle of read latency, so data passes straight
  // through in the response cycle; out-of-range fetches return a NOP (zero).
  assign fetch_rdata = (fetch_rvalid && !fetch_oor_q) ? mem_rdata : '0;

`ifdef IMEM_ARB_ERR_EN
  // Sticky flag for loader writes that were dropped as out of range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_err <= 1'b0;
    end else if (grant_ld && ld_oor) begin
      ld_err <= 1'b1;
    end
  end
`else
  assign ld_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Testbench for imem_arbiter: directed vectors, scoreboard queue for fetch
// responses popped by an independent monitor, behavioural 1-cycle memory.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        stall_fetch;
  logic        fetch_rvalid;
  logic [31:0] fetch_rdata;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_wdata;
  logic        ld_ready;
  logic        ld_err;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

`ifdef IMEM_ARB_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] sb_q[$];
  logic [31:0] tb_mem [256];

  imem_arbiter #(.MAX_LD_RUN(4), .DEPTH_WORDS(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .stall_fetch(stall_fetch),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_ready(ld_ready), .ld_err(ld_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory, 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tb_mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= tb_mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every response must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && fetch_rvalid === 1'b1) begin
      if (sb_q.size() == 0) chk("unexpected_rvalid", 32'd1, 32'd0);
      else chk("fetch_rdata", fetch_rdata, sb_q.pop_front());
    end
  end

  // One cycle: drive, check combinational outputs mid-cycle, queue expected read.
  task automatic step(input string tag,
                      input logic fr, input logic [31:0] fa,
                      input logic lv, input logic [31:0] la, input logic [31:0] lw,
                      input logic e_stall, input logic e_ready,
                      input logic e_en, input logic e_we, input logic [7:0] e_addr,
                      input logic push, input logic [31:0] e_data);
    fetch_req = fr; fetch_addr = fa;
    ld_valid = lv; ld_addr = la; ld_wdata = lw;
    @(negedge clk);
    chk({tag, ".stall"}, 32'(stall_fetch), 32'(e_stall));
    chk({tag, ".ld_ready"}, 32'(ld_ready), 32'(e_ready));
    chk({tag, ".mem_en"}, 32'(mem_en), 32'(e_en));
    chk({tag, ".mem_we"}, 32'(mem_we), 32'(e_we));
    if (e_en) chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(e_addr));
    if (e_we) chk({tag, ".mem_wdata"}, mem_wdata, lw);
    if (push) sb_q.push_back(e_data);
    @(posedge clk); #1;
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 1'b0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = 32'hA500_0000 | 32'(i);
    rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.rvalid", 32'(fetch_rvalid), 32'd0);
    chk("rst.rdata", fetch_rdata, 32'd0);
    chk("rst.ld_err", 32'(ld_err), 32'd0);
    chk("rst.mem_en", 32'(mem_en), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    idle("idle");

    // Fetch-only streaming
    step("f0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 32'hA500_0000);
    step("f1", 1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 1'b1, 32'hA500_0001);
    step("f2", 1'b1, 32'h8, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 1'b1, 32'hA500_0002);
    idle("idle2");

    // Write-then-read same address
    step("wr", 1'b1, 32'h10, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 1'b1, 8'd4, 1'b0, 32'h0);
    step("rd", 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4, 1'b1, 32'hDEAD_BEEF);

    // Out of range write and fetch
    chk("pre_oor.ld_err", 32'(ld_err), 32'd0);
    step("oor_w", 1'b1, 32'h400, 1'b1, 32'h400, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 32'h0);
    step("oor_f", 1'b1, 32'h400, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 32'h0);
    step("f0_again", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 32'hA500_0000);
    chk("oor.ld_err", 32'(ld_err), 32'(ERR_EXP));

    // Starvation: 4 loader grants then 1 fetch, repeated
    for (int i = 0; i < 10; i++) begin
      if ((i % 5) != 4)
        step("starve_ld", 1'b1, 32'h20, 1'b1, 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i),
             1'b1, 1'b1, 1'b1, 1'b1, 8'(64 + i), 1'b0, 32'h0);
      else
        step("starve_f", 1'b1, 32'h20, 1'b1, 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i),
             1'b0, 1'b0, 1'b1, 1'b0, 8'd8, 1'b1, 32'hA500_0008);
    end

    // Reset one cycle after a fetch grant: response must be suppressed
    step("pre_rst_f", 1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 1'b0, 32'h0);
    fetch_req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst.rvalid", 32'(fetch_rvalid), 32'd0);
    chk("midrst.rdata", fetch_rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst.rvalid", 32'(fetch_rvalid), 32'd0);
    chk("post_rst.ld_err", 32'(ld_err), 32'd0);
    @(posedge clk); #1;

    // Run counter must restart from zero after reset
    step("pre_ld0", 1'b1, 32'h24, 1'b1, 32'h200, 32'h5555_0000, 1'b1, 1'b1, 1'b1, 1'b1, 8'd128, 1'b0, 32'h0);
    step("pre_ld1", 1'b1, 32'h24, 1'b1, 32'h204, 32'h5555_0001, 1'b1, 1'b1, 1'b1, 1'b1, 8'd129, 1'b0, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_comb.ld_ready", 32'(ld_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i != 4)
        step("cnt_ld", 1'b1, 32'h24, 1'b1, 32'h210 + 32'(4 * i), 32'h6666_0000 + 32'(i),
             1'b1, 1'b1, 1'b1, 1'b1, 8'(132 + i), 1'b0, 32'h0);
      else
        step("cnt_f", 1'b1, 32'h24, 1'b1, 32'h210 + 32'(4 * i), 32'h6666_0000 + 32'(i),
             1'b0, 1'b0, 1'b1, 1'b0, 8'd9, 1'b1, 32'hA500_0009);
    end
    idle("idle_end");
    idle("idle_end2");

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
